// File: rtl/cb_filter_pkg.sv
// Shared types and constants for the counting Bloom filter family.
package cb_filter_pkg;

    // Per-hash seeding: permutation seed and XOR whitening seed (64 bits total)
    typedef struct packed {
        logic [31:0] PermuteSeed;
        logic [31:0] XorSeed;
    } cb_seed_t;

    // Example seed set for three hash functions
    localparam cb_seed_t [2:0] EgSeeds = {
        cb_seed_t'{PermuteSeed: 32'd299034753, XorSeed: 32'd4094834},
        cb_seed_t'{PermuteSeed: 32'd19921030,  XorSeed: 32'd995713},
        cb_seed_t'{PermuteSeed: 32'd294388,    XorSeed: 32'd65146511}
    };

    // Sweep engine state
    typedef enum logic {
        CbIdle  = 1'b0,
        CbClear = 1'b1
    } cb_sweep_state_e;

endpackage

// File: rtl/cb_filter_hash.sv
// One seeded hash: rotate by the permute seed, XOR with the replicated XOR
// seed (repeated HashRounds times), then XOR-fold down to a bucket index.
module cb_filter_hash
    import cb_filter_pkg::*;
#(
    parameter int unsigned InpWidth   = 32,
    parameter int unsigned HashWidth  = 4,
    parameter int unsigned HashRounds = 1,
    parameter cb_seed_t    Seed       = '0
) (
    input  logic [InpWidth-1:0]       data,
    output logic [HashWidth-1:0]      idx,
    output logic [2**HashWidth-1:0]   sel
);

    // Rotation distance is fixed at elaboration; a rotation is always a bijection
    localparam int unsigned RotAmt = Seed.PermuteSeed % InpWidth;

    logic [InpWidth-1:0] mixed_s;

    function automatic logic [InpWidth-1:0] hash_round(input logic [InpWidth-1:0] v);
        logic [InpWidth-1:0] rot_v;
        rot_v = '0;
        for (int unsigned j = 0; j < InpWidth; j++) begin
            rot_v[(j + RotAmt) % InpWidth] = v[j];
        end
        for (int unsigned j = 0; j < InpWidth; j++) begin
            rot_v[j] = rot_v[j] ^ Seed.XorSeed[j % 32];
        end
        return rot_v;
    endfunction

    // Mix the key and fold it into an index plus its one-hot select
    always_comb begin
        mixed_s = data;
        for (int unsigned r = 0; r < HashRounds; r++) begin
            mixed_s = hash_round(mixed_s);
        end
        idx = '0;
        for (int unsigned j = 0; j < InpWidth; j++) begin
            idx[j % HashWidth] = idx[j % HashWidth] ^ mixed_s[j];
        end
        sel = '0;
        sel[idx] = 1'b1;
    end

endmodule

// File: rtl/cb_filter_sweep.sv
// Counting Bloom filter with saturating sticky buckets, error reporting,
// occupancy status and a multi-cycle sweeping clear engine.
module cb_filter_sweep
    import cb_filter_pkg::*;
#(
    parameter int unsigned KHashes       = 3,
    parameter int unsigned HashWidth     = 4,
    parameter int unsigned HashRounds    = 1,
    parameter int unsigned InpWidth      = 32,
    parameter int unsigned BucketWidth   = 4,
    parameter int unsigned ClearPerCycle = 4,
    parameter cb_seed_t [KHashes-1:0] Seeds = EgSeeds
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [InpWidth-1:0]  look_data_i,
    output logic                 look_valid_o,
    input  logic [InpWidth-1:0]  incr_data_i,
    input  logic                 incr_valid_i,
    output logic                 incr_ready_o,
    input  logic [InpWidth-1:0]  decr_data_i,
    input  logic                 decr_valid_i,
    output logic                 decr_ready_o,
    input  logic                 clear_req_i,
    output logic                 clear_busy_o,
    output logic [HashWidth:0]   filter_usage_o,
    output logic                 filter_full_o,
    output logic                 filter_empty_o,
    output logic                 filter_error_o
);

    localparam int unsigned NumBuckets = 2**HashWidth;
    localparam int unsigned NumGroups  = NumBuckets / ClearPerCycle;
    localparam int unsigned PtrWidth   = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam logic [PtrWidth-1:0]    LastPtr   = PtrWidth'(NumGroups - 1);
    localparam logic [BucketWidth-1:0] MaxCntVal = '1;

    // Elaboration-time parameter sanity
    if (!((ClearPerCycle != 0) && ((ClearPerCycle & (ClearPerCycle - 1)) == 0) &&
          (ClearPerCycle <= NumBuckets))) begin : gen_cpc_check
        $error("ClearPerCycle must be a power of two no larger than NumBuckets");
    end
    if (($bits(Seeds) / 64) != KHashes) begin : gen_seed_check
        $error("Seeds must hold exactly KHashes entries");
    end
    if (BucketWidth < 1) begin : gen_bw_check
        $error("BucketWidth must be at least 1");
    end

    cb_sweep_state_e        state_r;
    logic [PtrWidth-1:0]    ptr_r;
    logic                   busy_r;
    logic                   ready_r;
    logic [BucketWidth-1:0] bucket_r     [NumBuckets];
    logic [BucketWidth-1:0] bucket_nxt_s [NumBuckets];
    logic [HashWidth:0]     usage_r;
    logic [HashWidth:0]     usage_nxt_s;
    logic                   full_r;
    logic                   empty_r;
    logic                   error_r;
    logic                   error_nxt_s;

    logic [HashWidth-1:0]   look_idx_s [KHashes];
    logic [HashWidth-1:0]   incr_idx_s [KHashes];
    logic [HashWidth-1:0]   decr_idx_s [KHashes];
    logic [NumBuckets-1:0]  look_sel_s [KHashes];
    logic [NumBuckets-1:0]  incr_sel_s [KHashes];
    logic [NumBuckets-1:0]  decr_sel_s [KHashes];
    logic [NumBuckets-1:0]  incr_mask_s;
    logic [NumBuckets-1:0]  decr_mask_s;
    logic [NumBuckets-1:0]  nonzero_s;
    logic                   incr_fire_s;
    logic                   decr_fire_s;
    logic                   look_hit_s;
    logic                   unused_idx_s;

    for (genvar k = 0; k < KHashes; k++) begin : gen_hash
        cb_filter_hash #(
            .InpWidth   (InpWidth),
            .HashWidth  (HashWidth),
            .HashRounds (HashRounds),
            .Seed       (Seeds[k])
        ) u_look_hash (
            .data (look_data_i),
            .idx  (look_idx_s[k]),
            .sel  (look_sel_s[k])
        );
        cb_filter_hash #(
            .InpWidth   (InpWidth),
            .HashWidth  (HashWidth),
            .HashRounds (HashRounds),
            .Seed       (Seeds[k])
        ) u_incr_hash (
            .data (incr_data_i),
            .idx  (incr_idx_s[k]),
            .sel  (incr_sel_s[k])
        );
        cb_filter_hash #(
            .InpWidth   (InpWidth),
            .HashWidth  (HashWidth),
            .HashRounds (HashRounds),
            .Seed       (Seeds[k])
        ) u_decr_hash (
            .data (decr_data_i),
            .idx  (decr_idx_s[k]),
            .sel  (decr_sel_s[k])
        );
    end

    // Selection works on the one-hot vectors; the raw indices are not needed here
    always_comb begin
        unused_idx_s = 1'b0;
        for (int unsigned k = 0; k < KHashes; k++) begin
            unused_idx_s = unused_idx_s ^ (^{look_idx_s[k], incr_idx_s[k], decr_idx_s[k]});
        end
    end

    // Accepted updates; a clear sampled in the same cycle discards them silently
    assign incr_fire_s = incr_valid_i & ready_r & ~clear_req_i;
    assign decr_fire_s = decr_valid_i & ready_r & ~clear_req_i;

    // Merge the K selects so duplicate indices touch a bucket only once
    always_comb begin
        incr_mask_s = '0;
        decr_mask_s = '0;
        for (int unsigned k = 0; k < KHashes; k++) begin
            incr_mask_s = incr_mask_s | incr_sel_s[k];
            decr_mask_s = decr_mask_s | decr_sel_s[k];
        end
        if (!incr_fire_s) begin
            incr_mask_s = '0;
        end else begin
            incr_mask_s = incr_mask_s;
        end
        if (!decr_fire_s) begin
            decr_mask_s = '0;
        end else begin
            decr_mask_s = decr_mask_s;
        end
    end

    // Zero-cycle lookup: every selected bucket must be nonzero and no sweep running
    always_comb begin
        for (int unsigned b = 0; b < NumBuckets; b++) begin
            nonzero_s[b] = |bucket_r[b];
        end
        look_hit_s = ~busy_r;
        for (int unsigned k = 0; k < KHashes; k++) begin
            look_hit_s = look_hit_s & (|(look_sel_s[k] & nonzero_s));
        end
    end

    assign look_valid_o = look_hit_s;

    // Next bucket values: sweep zeroing, saturating increment, sticky decrement
    always_comb begin
        error_nxt_s = 1'b0;
        usage_nxt_s = '0;
        for (int unsigned b = 0; b < NumBuckets; b++) begin
            bucket_nxt_s[b] = bucket_r[b];
            if ((state_r == CbClear) && ((b / ClearPerCycle) == 32'(ptr_r))) begin
                bucket_nxt_s[b] = '0;
            end else if (incr_mask_s[b] && decr_mask_s[b]) begin
                bucket_nxt_s[b] = bucket_r[b];
            end else if (incr_mask_s[b]) begin
                if (bucket_r[b] == MaxCntVal) begin
                    error_nxt_s = 1'b1;
                end else begin
                    bucket_nxt_s[b] = bucket_r[b] + BucketWidth'(1);
                end
            end else if (decr_mask_s[b]) begin
                if (bucket_r[b] == MaxCntVal) begin
                    bucket_nxt_s[b] = bucket_r[b];
                end else if (bucket_r[b] == '0) begin
                    error_nxt_s = 1'b1;
                end else begin
                    bucket_nxt_s[b] = bucket_r[b] - BucketWidth'(1);
                end
            end else begin
                bucket_nxt_s[b] = bucket_r[b];
            end
            usage_nxt_s = usage_nxt_s + (HashWidth+1)'(|bucket_nxt_s[b]);
        end
    end

    // Bucket array and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < NumBuckets; b++) begin
                bucket_r[b] <= '0;
            end
            usage_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            error_r <= 1'b0;
        end else begin
            for (int unsigned b = 0; b < NumBuckets; b++) begin
                bucket_r[b] <= bucket_nxt_s[b];
            end
            usage_r <= usage_nxt_s;
            full_r  <= (usage_nxt_s == (HashWidth+1)'(NumBuckets));
            empty_r <= (usage_nxt_s == '0);
            error_r <= error_nxt_s;
        end
    end

    // Sweep FSM with state-derived busy and ready registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= CbIdle;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                CbIdle: begin
                    if (clear_req_i) begin
                        state_r <= CbClear;
                        ptr_r   <= '0;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= CbIdle;
                        ptr_r   <= '0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                CbClear: begin
                    if (ptr_r == LastPtr) begin
                        state_r <= CbIdle;
                        ptr_r   <= '0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= CbClear;
                        ptr_r   <= ptr_r + PtrWidth'(1);
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= CbIdle;
                    ptr_r   <= '0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign incr_ready_o   = ready_r;
    assign decr_ready_o   = ready_r;
    assign clear_busy_o   = busy_r;
    assign filter_usage_o = usage_r;
    assign filter_full_o  = full_r;
    assign filter_empty_o = empty_r;
    assign filter_error_o = error_r;

endmodule

// File: tb/tb_cb_filter_sweep.sv
// Directed and reference-model bench for cb_filter_sweep (2-bit buckets).
module tb_cb_filter_sweep;
    import cb_filter_pkg::*;

    localparam int NB   = 16;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] look_data = 32'd0;
    logic        look_valid;
    logic [31:0] incr_data = 32'd0;
    logic        incr_valid = 1'b0;
    logic        incr_ready;
    logic [31:0] decr_data = 32'd0;
    logic        decr_valid = 1'b0;
    logic        decr_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [4:0]  usage;
    logic        full;
    logic        empty;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cnt [NB];

    cb_filter_sweep #(
        .KHashes(3), .HashWidth(4), .HashRounds(1), .InpWidth(32),
        .BucketWidth(2), .ClearPerCycle(4), .Seeds(EgSeeds)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .look_data_i(look_data), .look_valid_o(look_valid),
        .incr_data_i(incr_data), .incr_valid_i(incr_valid), .incr_ready_o(incr_ready),
        .decr_data_i(decr_data), .decr_valid_i(decr_valid), .decr_ready_o(decr_ready),
        .clear_req_i(clear_req), .clear_busy_o(clear_busy),
        .filter_usage_o(usage), .filter_full_o(full),
        .filter_empty_o(empty), .filter_error_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv;
        logic [31:0] ik;
        bit          dv;
        logic [31:0] dk;
        logic [31:0] lk;
        bit          exp_err;
        bit          exp_look;
        bit          exp_empty;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(bit iv, logic [31:0] ik, bit dv, logic [31:0] dk,
                                logic [31:0] lk, bit ee, bit el, bit em);
        vec_t v;
        v.iv = iv; v.ik = ik; v.dv = dv; v.dk = dk; v.lk = lk;
        v.exp_err = ee; v.exp_look = el; v.exp_empty = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference hash: rotate-left, XOR with seed, fold nibbles together
    function automatic int model_hash(logic [31:0] key, int k);
        logic [31:0] v;
        logic [3:0]  idx;
        int          r;
        v   = key;
        r   = int'(EgSeeds[k].PermuteSeed % 32'd32);
        v   = (v << r) | (v >> (32 - r));
        v   = v ^ EgSeeds[k].XorSeed;
        idx = 4'd0;
        for (int c = 0; c < 8; c++) idx = idx ^ v[c*4 +: 4];
        return int'(idx);
    endfunction

    function automatic bit model_step(bit iv, logic [31:0] ik, bit dv, logic [31:0] dk);
        bit im [NB];
        bit dm [NB];
        bit e;
        e = 1'b0;
        for (int b = 0; b < NB; b++) begin im[b] = 1'b0; dm[b] = 1'b0; end
        for (int k = 0; k < 3; k++) begin
            if (iv) im[model_hash(ik, k)] = 1'b1;
            if (dv) dm[model_hash(dk, k)] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (im[b] && dm[b]) begin
                // net zero
            end else if (im[b]) begin
                if (cnt[b] == MAXC) e = 1'b1; else cnt[b]++;
            end else if (dm[b]) begin
                if (cnt[b] == MAXC) begin end
                else if (cnt[b] == 0) e = 1'b1;
                else cnt[b]--;
            end
        end
        return e;
    endfunction

    function automatic int model_usage();
        int u;
        u = 0;
        for (int b = 0; b < NB; b++) if (cnt[b] != 0) u++;
        return u;
    endfunction

    function automatic bit model_look(logic [31:0] key);
        bit h;
        h = 1'b1;
        for (int k = 0; k < 3; k++) if (cnt[model_hash(key, k)] == 0) h = 1'b0;
        return h;
    endfunction

    function automatic void model_clear();
        for (int b = 0; b < NB; b++) cnt[b] = 0;
    endfunction

    // Called at a negedge in IDLE; returns at the following negedge
    task automatic step(input bit iv, input logic [31:0] ik, input bit dv,
                        input logic [31:0] dk, input logic [31:0] lk, output bit e);
        incr_valid = iv; incr_data = ik;
        decr_valid = dv; decr_data = dk;
        look_data  = lk;
        e = model_step(iv, ik, dv, dk);
        @(posedge clk);
        @(negedge clk);
        incr_valid = 1'b0;
        decr_valid = 1'b0;
    endtask

    logic [31:0] keys [8];
    logic [31:0] pool [6];
    bit          e;
    int          u_before;

    initial begin
        model_clear();
        tbl[0]  = mk(1, 32'h0000_1234, 0, 32'h0, 32'h0000_1234, 0, 1, 0);
        tbl[1]  = mk(0, 32'h0, 1, 32'h0000_1234, 32'h0000_1234, 0, 0, 1);
        tbl[2]  = mk(0, 32'h0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1);
        tbl[3]  = mk(0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1);
        tbl[4]  = mk(1, 32'h0000_A5A5, 0, 32'h0, 32'h0000_A5A5, 0, 1, 0);
        tbl[5]  = mk(1, 32'h0000_A5A5, 0, 32'h0, 32'h0000_A5A5, 0, 1, 0);
        tbl[6]  = mk(1, 32'h0000_A5A5, 0, 32'h0, 32'h0000_A5A5, 0, 1, 0);
        tbl[7]  = mk(1, 32'h0000_A5A5, 0, 32'h0, 32'h0000_A5A5, 1, 1, 0);
        tbl[8]  = mk(1, 32'h0000_A5A5, 0, 32'h0, 32'h0000_A5A5, 1, 1, 0);
        for (int i = 9; i < 15; i++)
            tbl[i] = mk(0, 32'h0, 1, 32'h0000_A5A5, 32'h0000_A5A5, 0, 1, 0);
        keys = '{32'h11, 32'h2222, 32'h3333_0000, 32'h4444_4444,
                 32'h5A5A_0001, 32'h0F0F_F0F0, 32'h1357_9BDF, 32'hCAFE_F00D};
        pool = '{32'h1, 32'h2, 32'hBEEF, 32'h1234_5678, 32'h8000_0000, 32'h0000_A5A5};

        // Reset values
        look_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rst look", look_valid, 0);
        check("rst usage", usage, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst error", err, 0);
        check("rst busy", clear_busy, 0);
        check("rst incr_ready", incr_ready, 1);
        check("rst decr_ready", decr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].iv, tbl[i].ik, tbl[i].dv, tbl[i].dk, tbl[i].lk, e);
            check($sformatf("vec%0d error", i), err, tbl[i].exp_err);
            check($sformatf("vec%0d look", i), look_valid, tbl[i].exp_look);
            check($sformatf("vec%0d empty", i), empty, tbl[i].exp_empty);
            check($sformatf("vec%0d usage", i), usage, model_usage());
            if (i == 0) check("vec0 usage range", (usage >= 1 && usage <= 3), 1);
        end

        // Insert 8 keys, then clear with a colliding increment that must vanish
        for (int i = 0; i < 8; i++) step(1, keys[i], 0, 32'h0, keys[i], e);
        check("pre-clear usage", usage, model_usage());
        check("pre-clear look", look_valid, 1);
        clear_req = 1'b1; incr_valid = 1'b1; incr_data = 32'h7777_7777;
        look_data = keys[0];
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0; incr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("clr%0d busy", c), clear_busy, 1);
            check($sformatf("clr%0d incr_ready", c), incr_ready, 0);
            check($sformatf("clr%0d decr_ready", c), decr_ready, 0);
            check($sformatf("clr%0d look", c), look_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        model_clear();
        check("post-clear busy", clear_busy, 0);
        check("post-clear ready", incr_ready & decr_ready, 1);
        check("post-clear usage", usage, 0);
        check("post-clear empty", empty, 1);
        check("post-clear error", err, 0);
        check("post-clear look key0", look_valid, 0);
        look_data = 32'h7777_7777;
        #1 check("discarded incr look", look_valid, 0);

        // Same key on both ports at count 1
        step(1, 32'h0000_1234, 0, 32'h0, 32'h0000_1234, e);
        u_before = model_usage();
        step(1, 32'h0000_1234, 1, 32'h0000_1234, 32'h0000_1234, e);
        check("both error", err, 0);
        check("both look", look_valid, 1);
        check("both usage", usage, u_before);
        step(0, 32'h0, 1, 32'h0000_1234, 32'h0000_1234, e);
        check("both then decr empty", empty, 1);
        check("both then decr error", err, 0);

        // Random sequence against the reference model
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                 pool[$urandom_range(0, 5)], e);
            check($sformatf("rnd%0d error", i), err, e);
            check($sformatf("rnd%0d usage", i), usage, model_usage());
            check($sformatf("rnd%0d look", i), look_valid, model_look(look_data));
            check($sformatf("rnd%0d full", i), full, model_usage() == NB);
        end

        // Reset asserted mid-sweep
        clear_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst busy", clear_busy, 0);
        check("midrst ready", incr_ready & decr_ready, 1);
        check("midrst usage", usage, 0);
        check("midrst empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after midrst busy", clear_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_filter_sweep.md
# cb_filter_sweep

Parametrised counting Bloom filter with K seeded hash functions, saturating bucket counters, valid/ready increment and decrement ports, and a multi-cycle sweeping clear engine. It sits beside transaction trackers (ID/address filters) to answer "possibly present / definitely absent" queries in zero cycles. Seeding uses the `cb_seed_t` type from `cb_filter_pkg`. Compared with a single-cycle filter it adds:
- counter saturation with sticky buckets;
- underflow and saturation error reporting;
- occupancy status;
- a clear that sweeps `ClearPerCycle` buckets per cycle, modelling SRAM-backed bucket arrays.

## Interface
Parameters:
- `KHashes`, 3: number of hash functions; `Seeds` must have `KHashes` entries.
- `HashWidth`, 4: bucket index width; `NumBuckets = 2**HashWidth`.
- `HashRounds`, 1: permute/XOR rounds per hash.
- `InpWidth`, 32: key width.
- `BucketWidth`, 4: counter width; `MaxCnt = 2**BucketWidth-1`.
- `ClearPerCycle`, 4: buckets zeroed per clear cycle; power of two, at most `NumBuckets`.
- `Seeds`, `cb_filter_pkg::EgSeeds`: `cb_seed_t [KHashes-1:0]`.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous reset, active low
- `look_data_i`  in  InpWidth  lookup key
- `look_valid_o`  out  1  key possibly present
- `incr_data_i`  in  InpWidth  key to insert
- `incr_valid_i` / `incr_ready_o`  in/out  1  insert handshake
- `decr_data_i`  in  InpWidth  key to remove
- `decr_valid_i` / `decr_ready_o`  in/out  1  remove handshake
- `clear_req_i`  in  1  start clear (level-sampled in IDLE)
- `clear_busy_o`  out  1  sweep in progress
- `filter_usage_o`  out  HashWidth+1  number of nonzero buckets
- `filter_full_o`  out  1  `usage == NumBuckets`
- `filter_empty_o`  out  1  `usage == 0`
- `filter_error_o`  out  1  one-cycle pulse on saturation hit or underflow

## Operation
- Hash i: permute key by `Seeds[i].PermuteSeed`, XOR with `Seeds[i].XorSeed`, repeated `HashRounds` times, then XOR-fold to `HashWidth` bits. Each hash gives one index.
- Index selection: a bucket is selected if any of the K indices equals it. Duplicate indices count once (±1 per bucket per operation).
- Lookup: `look_valid_o` = all K selected buckets nonzero. It is combinational and forced 0 while `clear_busy_o`.
- Increment (on handshake): each selected bucket +1.
  - A bucket already at `MaxCnt` is unchanged and raises the error pulse.
  - Saturated buckets are sticky: decrements never lower them, and raise no error. This guarantees no false negatives.
- Decrement (on handshake): each selected bucket below `MaxCnt` and nonzero is decremented by 1.
  - If any selected bucket is zero, that bucket stays zero and the error pulse is raised.
- Simultaneous increment and decrement on the same bucket: net zero, no error, except:
  - bucket at 0: becomes 0, no error;
  - bucket at `MaxCnt`: stays `MaxCnt`, no error.
- FSM:
  - IDLE: `incr_ready_o = decr_ready_o = 1`. `clear_req_i` → CLEAR with sweep pointer 0.
  - CLEAR: each cycle zero buckets `[ptr*ClearPerCycle +: ClearPerCycle]`, then increment ptr. After the last group → IDLE. Readies are 0; `clear_req_i` is ignored.
- Clear dominance: an update handshaking in the same cycle that `clear_req_i` is sampled in IDLE completes its handshake, but it is discarded with no error.
- `filter_usage_o` is a registered popcount of nonzero buckets, recomputed from next-state bucket values.

## Timing
- Reset values: all buckets 0, state IDLE, `filter_usage_o` 0, `filter_empty_o` 1, `filter_full_o` 0, `filter_error_o` 0, `clear_busy_o` 0, readies 1.
- Lookup: 0-cycle. An update accepted in cycle n is visible to lookup and usage in cycle n+1.
- Error: registered, high in cycle n+1 for exactly one cycle per offending cycle n.
- Clear: `clear_busy_o` is high for exactly `NumBuckets/ClearPerCycle` cycles, starting the cycle after the request.
  - Usage reaches 0 one cycle after the final sweep cycle.
  - The cycle after the sweep ends, readies are 1 again.
- Reset asserted mid-sweep: immediate return to reset values.
- Readies are functions of state only (no valid→ready path).

## Structure
- In `cb_filter_pkg`: `cb_seed_t` (existing), `EgSeeds` (existing), and a new `typedef enum logic {CbIdle, CbClear} cb_sweep_state_e`.
- Sub-module `cb_filter_hash`: one hash instance per K. Parameters: InpWidth, HashWidth, HashRounds, seed. It outputs an index and a one-hot select vector.
- Elaboration assertions:
  - `ClearPerCycle` is a power of two and at most `NumBuckets`;
  - `$bits(Seeds)/64 == KHashes`;
  - `BucketWidth >= 1`.

## Test plan
- Reset: lookup 0xDEADBEEF → `look_valid_o` 0, usage 0, empty 1, error 0.
- Increment 0x0000_1234 once → next cycle lookup hit; usage equals the distinct-index count (1..3) from the model. Then decrement it → empty 1, lookup miss.
- With `BucketWidth`=2, increment 0xA5A5 5× → error pulses after the 4th and 5th; buckets at 3. Then decrement 6× → lookup still hits, no errors.
- Decrement an absent key on an empty filter → error high exactly one cycle, usage stays 0.
- With NumBuckets 16 and `ClearPerCycle` 4: insert 8 keys, pulse `clear_req_i` → busy high 4 cycles, readies 0, lookup 0. Then empty 1 and readies 1; an increment in the request cycle leaves no trace.
- Same key on incr and decr in one cycle, at count 1 → count stays 1, no error; also run a random sequence against a reference model.
